// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bus: redirect/stall controls from decode, ROM address/data,
// and the IF/ID register presented downstream.
interface inst_fetch_unit_if #(
    parameter int PC_WIDTH = 5
);
    logic                stall;
    logic                halt_req;
    logic                branch_taken;
    logic [15:0]         branch_offset;
    logic                jump;
    logic [25:0]         jump_target;
    logic [31:0]         rom_inst;
    logic [PC_WIDTH-1:0] pc;
    logic [31:0]         if_inst;
    logic [PC_WIDTH-1:0] if_pc;
    logic                if_valid;
    logic                halted;

    modport master (
        input  stall, halt_req, branch_taken, branch_offset, jump, jump_target, rom_inst,
        output pc, if_inst, if_pc, if_valid, halted
    );

    modport slave (
        output stall, halt_req, branch_taken, branch_offset, jump, jump_target, rom_inst,
        input  pc, if_inst, if_pc, if_valid, halted
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, latches ROM output into IF/ID,
// handles branch/jump redirects with a one-bubble squash, stall and halt.
module inst_fetch_unit #(
    parameter int PC_WIDTH = 5,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst,
    inst_fetch_unit_if.master  bus
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         inst_q, inst_d;
    logic [PC_WIDTH-1:0] ifpc_q, ifpc_d;
    logic                vld_q, vld_d;
    logic [PC_WIDTH-1:0] br_target;
    logic                unused_hi;

    // Offset/target bits above the PC width are discarded by the mod-2^N wrap.
    assign unused_hi = ^{bus.branch_offset[15:PC_WIDTH], bus.jump_target[25:PC_WIDTH]};
    assign br_target = ifpc_q + PC_WIDTH'(1) + bus.branch_offset[PC_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= PC_WIDTH'(RESET_PC);
            inst_q  <= '0;
            ifpc_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            ifpc_q  <= ifpc_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        ifpc_d  = ifpc_q;
        vld_d   = vld_q;
        unique case (state_q)
            BOOT: begin
                if (!bus.stall) begin
                    inst_d  = bus.rom_inst;
                    ifpc_d  = pc_q;
                    vld_d   = 1'b1;
                    pc_d    = pc_q + PC_WIDTH'(1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.halt_req) begin
                    state_d = HALT;
                    vld_d   = 1'b0;
                end else if (vld_q && (bus.jump || bus.branch_taken)) begin
                    // Squash the wrong-path word currently being read at pc.
                    pc_d   = bus.jump ? bus.jump_target[PC_WIDTH-1:0] : br_target;
                    inst_d = '0;
                    vld_d  = 1'b0;
                end else if (!bus.stall) begin
                    inst_d = bus.rom_inst;
                    ifpc_d = pc_q;
                    vld_d  = 1'b1;
                    pc_d   = pc_q + PC_WIDTH'(1);
                end
            end
            HALT: vld_d = 1'b0;
            default: state_d = BOOT;
        endcase
    end

    assign bus.pc       = pc_q;
    assign bus.if_inst  = inst_q;
    assign bus.if_pc    = ifpc_q;
    assign bus.if_valid = vld_q;
    assign bus.halted   = (state_q == HALT);
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus random
// traffic, all checked against a cycle-level behavioural model.
module tb_inst_fetch_unit;
    localparam int PW  = 5;
    localparam int DEP = 1 << PW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_fetch_unit_if #(.PC_WIDTH(PW)) bus();
    inst_fetch_unit #(.PC_WIDTH(PW), .RESET_PC(0)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] rom [DEP];
    assign bus.rom_inst = rom[bus.pc];

    // Reference model state
    int          m_pc, m_ifpc;
    logic [31:0] m_inst;
    logic        m_valid, m_halted, m_boot;
    int          chk_cnt = 0;
    int          pass_cnt = 0;

    // Advance the model from the current inputs, then clock the DUT.
    task automatic tick();
        logic signed [15:0] so;
        int t;
        so = bus.branch_offset;
        if (rst) begin
            m_pc = 0; m_ifpc = 0; m_inst = 0; m_valid = 0; m_halted = 0; m_boot = 1;
        end else if (m_halted) begin
            m_valid = 0;
        end else if (m_boot) begin
            if (!bus.stall) begin
                m_inst = rom[m_pc]; m_ifpc = m_pc; m_valid = 1;
                m_pc = (m_pc + 1) % DEP; m_boot = 0;
            end
        end else if (bus.halt_req) begin
            m_halted = 1; m_valid = 0;
        end else if (m_valid && (bus.jump || bus.branch_taken)) begin
            if (bus.jump) m_pc = int'(bus.jump_target) % DEP;
            else begin
                t = m_ifpc + 1 + so;
                m_pc = ((t % DEP) + DEP) % DEP;
            end
            m_inst = 0; m_valid = 0;
        end else if (!bus.stall) begin
            m_inst = rom[m_pc]; m_ifpc = m_pc; m_valid = 1;
            m_pc = (m_pc + 1) % DEP;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall = 0; bus.halt_req = 0; bus.branch_taken = 0; bus.jump = 0;
        bus.branch_offset = '0; bus.jump_target = '0;
    endtask

    task automatic do_reset();
        rst = 1; tick(); rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; tick(); tick(); rst = 0;
        chk_cnt++; if (bus.pc !== 5'd0) $display("FAIL reset_pc: got %0h want 0", bus.pc); else pass_cnt++;
        chk_cnt++; if (bus.if_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", bus.if_valid); else pass_cnt++;
        chk_cnt++; if (bus.halted !== 1'b0) $display("FAIL reset_halted: got %0b want 0", bus.halted); else pass_cnt++;
        chk_cnt++; if (bus.if_inst !== 32'd0) $display("FAIL reset_inst: got %0h want 0", bus.if_inst); else pass_cnt++;
        chk_cnt++; if (bus.if_pc !== 5'd0) $display("FAIL reset_ifpc: got %0h want 0", bus.if_pc); else pass_cnt++;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 5; i++) begin
            chk_cnt++; if (bus.pc !== PW'(i)) $display("FAIL seq_pc[%0d]: got %0h want %0h", i, bus.pc, i); else pass_cnt++;
            chk_cnt++; if (bus.if_valid !== (i > 0)) $display("FAIL seq_valid[%0d]: got %0b want %0b", i, bus.if_valid, i > 0); else pass_cnt++;
            if (i < 4) tick();
        end
        chk_cnt++; if (bus.if_pc !== 5'd3) $display("FAIL seq_ifpc: got %0h want 3", bus.if_pc); else pass_cnt++;
        chk_cnt++; if (bus.if_inst !== rom[3]) $display("FAIL seq_inst: got %0h want %0h", bus.if_inst, rom[3]); else pass_cnt++;
    endtask

    task automatic test_branch();
        int n = 0;
        while (!(m_ifpc == 10 && m_valid) && n < 64) begin tick(); n++; end
        chk_cnt++; if (bus.if_pc !== 5'h0A) $display("FAIL br_reach: got %0h want 0a", bus.if_pc); else pass_cnt++;
        bus.branch_taken = 1; bus.branch_offset = 16'h0001; tick(); idle_inputs();
        chk_cnt++; if (bus.pc !== 5'h0C) $display("FAIL br_pc: got %0h want 0c", bus.pc); else pass_cnt++;
        chk_cnt++; if (bus.if_valid !== 1'b0) $display("FAIL br_bubble: got %0b want 0", bus.if_valid); else pass_cnt++;
        chk_cnt++; if (bus.if_inst !== 32'd0) $display("FAIL br_squash: got %0h want 0", bus.if_inst); else pass_cnt++;
        tick();
        chk_cnt++; if (bus.if_pc !== 5'h0C) $display("FAIL br_ifpc: got %0h want 0c", bus.if_pc); else pass_cnt++;
        chk_cnt++; if (bus.if_inst !== rom[12]) $display("FAIL br_inst: got %0h want %0h", bus.if_inst, rom[12]); else pass_cnt++;
    endtask

    task automatic test_jump();
        bus.jump = 1; bus.jump_target = 26'h0000008;
        bus.branch_taken = 1; bus.branch_offset = 16'h0005;
        tick(); idle_inputs();
        chk_cnt++; if (bus.pc !== 5'h08) $display("FAIL jmp_pc: got %0h want 08", bus.pc); else pass_cnt++;
        chk_cnt++; if (bus.if_valid !== 1'b0) $display("FAIL jmp_bubble: got %0b want 0", bus.if_valid); else pass_cnt++;
        chk_cnt++; if (bus.if_pc !== 5'h0C) $display("FAIL jmp_ifpc_hold: got %0h want 0c", bus.if_pc); else pass_cnt++;
        tick();
        chk_cnt++; if (bus.if_pc !== 5'h08) $display("FAIL jmp_ifpc: got %0h want 08", bus.if_pc); else pass_cnt++;
        chk_cnt++; if (bus.if_inst !== rom[8]) $display("FAIL jmp_inst: got %0h want %0h", bus.if_inst, rom[8]); else pass_cnt++;
    endtask

    task automatic test_stall();
        logic [31:0] inst0;
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        inst0 = bus.if_inst;
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_cnt++; if (bus.pc !== 5'd5) $display("FAIL stall_pc[%0d]: got %0h want 5", i, bus.pc); else pass_cnt++;
            chk_cnt++; if (bus.if_pc !== 5'd4) $display("FAIL stall_ifpc[%0d]: got %0h want 4", i, bus.if_pc); else pass_cnt++;
            chk_cnt++; if (bus.if_inst !== rom[4] || inst0 !== rom[4]) $display("FAIL stall_inst[%0d]: got %0h want %0h", i, bus.if_inst, rom[4]); else pass_cnt++;
            chk_cnt++; if (bus.if_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %0b want 1", i, bus.if_valid); else pass_cnt++;
        end
        bus.branch_taken = 1; bus.branch_offset = 16'hFFFE; tick(); idle_inputs();
        chk_cnt++; if (bus.pc !== 5'd3) $display("FAIL stall_br_pc: got %0h want 3", bus.pc); else pass_cnt++;
        chk_cnt++; if (bus.if_valid !== 1'b0) $display("FAIL stall_br_bubble: got %0b want 0", bus.if_valid); else pass_cnt++;
    endtask

    task automatic test_wrap();
        int n = 0;
        while (m_pc != 31 && n < 64) begin tick(); n++; end
        chk_cnt++; if (bus.pc !== 5'h1F) $display("FAIL wrap_reach: got %0h want 1f", bus.pc); else pass_cnt++;
        tick();
        chk_cnt++; if (bus.pc !== 5'h00) $display("FAIL wrap_pc: got %0h want 00", bus.pc); else pass_cnt++;
        chk_cnt++; if (bus.if_pc !== 5'h1F) $display("FAIL wrap_ifpc: got %0h want 1f", bus.if_pc); else pass_cnt++;
        n = 0;
        while (!(m_ifpc == 30 && m_valid) && n < 64) begin tick(); n++; end
        chk_cnt++; if (bus.if_pc !== 5'h1E) $display("FAIL wrapbr_reach: got %0h want 1e", bus.if_pc); else pass_cnt++;
        bus.branch_taken = 1; bus.branch_offset = 16'h0003; tick(); idle_inputs();
        chk_cnt++; if (bus.pc !== 5'h02) $display("FAIL wrapbr_pc: got %0h want 02", bus.pc); else pass_cnt++;
    endtask

    task automatic test_halt();
        int n = 0;
        while (m_pc != 7 && n < 64) begin tick(); n++; end
        chk_cnt++; if (bus.pc !== 5'd7) $display("FAIL halt_reach: got %0h want 7", bus.pc); else pass_cnt++;
        bus.halt_req = 1; tick(); bus.halt_req = 0;
        for (int i = 0; i < 5; i++) begin
            chk_cnt++; if (bus.halted !== 1'b1) $display("FAIL halt_flag[%0d]: got %0b want 1", i, bus.halted); else pass_cnt++;
            chk_cnt++; if (bus.if_valid !== 1'b0) $display("FAIL halt_valid[%0d]: got %0b want 0", i, bus.if_valid); else pass_cnt++;
            chk_cnt++; if (bus.pc !== 5'd7) $display("FAIL halt_pc[%0d]: got %0h want 7", i, bus.pc); else pass_cnt++;
            bus.jump = 1; bus.jump_target = 26'($urandom); bus.stall = 1'($urandom);
            tick(); idle_inputs();
        end
        rst = 1; tick(); rst = 0;
        chk_cnt++; if (bus.pc !== 5'd0) $display("FAIL halt_rst_pc: got %0h want 0", bus.pc); else pass_cnt++;
        chk_cnt++; if (bus.halted !== 1'b0) $display("FAIL halt_rst_flag: got %0b want 0", bus.halted); else pass_cnt++;
        chk_cnt++; if (bus.if_valid !== 1'b0) $display("FAIL halt_rst_valid: got %0b want 0", bus.if_valid); else pass_cnt++;
        tick();
        chk_cnt++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 5'd0) $display("FAIL boot_first: got v=%0b pc=%0h want v=1 pc=0", bus.if_valid, bus.if_pc); else pass_cnt++;
        chk_cnt++; if (bus.if_inst !== rom[0]) $display("FAIL boot_inst: got %0h want %0h", bus.if_inst, rom[0]); else pass_cnt++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst              = ($urandom_range(0, 60) == 0);
            bus.stall        = ($urandom_range(0, 3) == 0);
            bus.halt_req     = ($urandom_range(0, 80) == 0);
            bus.branch_taken = ($urandom_range(0, 5) == 0);
            bus.jump         = ($urandom_range(0, 8) == 0);
            bus.branch_offset = 16'($urandom);
            bus.jump_target   = 26'($urandom);
            if (m_halted && $urandom_range(0, 6) == 0) rst = 1;
            tick();
            chk_cnt++;
            if (bus.pc !== PW'(m_pc) || bus.if_pc !== PW'(m_ifpc) || bus.if_inst !== m_inst ||
                bus.if_valid !== m_valid || bus.halted !== m_halted)
                $display("FAIL rand[%0d]: got pc=%0h ifpc=%0h inst=%0h v=%0b h=%0b want pc=%0h ifpc=%0h inst=%0h v=%0b h=%0b",
                         c, bus.pc, bus.if_pc, bus.if_inst, bus.if_valid, bus.halted,
                         m_pc, m_ifpc, m_inst, m_valid, m_halted);
            else pass_cnt++;
        end
        rst = 0; idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < DEP; i++) rom[i] = $urandom;
        rst = 1;
        idle_inputs();
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall();
        test_wrap();
        test_halt();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the 32-entry instruction ROM. It owns the 5-bit word-addressed program counter and drives it to the ROM address input.
- Each cycle it latches the ROM output into an IF/ID register so the decode stage sees the instruction alongside its PC.
- It accepts branch and jump redirects from decode, squashes the wrong-path fetch, and supports stall and halt.

Parameters:
- PC_WIDTH, 5, width of the word address; must match the ROM depth of 2^PC_WIDTH words.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- stall  input  1  hold PC and the IF/ID register.
- halt_req  input  1  stop fetching permanently until reset.
- branch_taken  input  1  decode resolved a taken beq for if_inst.
- branch_offset  input  16  signed word offset from the instruction's imm field.
- jump  input  1  decode decoded a j for if_inst.
- jump_target  input  26  target field of j, as a word address.
- rom_inst  input  32  instruction word returned by the ROM for pc (combinational).
- pc  output  PC_WIDTH  fetch address driven to the ROM.
- if_inst  output  32  latched instruction presented to decode.
- if_pc  output  PC_WIDTH  address of if_inst.
- if_valid  output  1  if_inst is a real instruction, not a bubble.
- halted  output  1  FSM is in the HALT state.

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high, and wins over every other input.
- Reset values: pc=RESET_PC, if_inst=0, if_pc=0, if_valid=0, halted=0, state=BOOT.
- States:
  - BOOT: lasts exactly one cycle after reset release. The ROM is read at RESET_PC. Next edge: IR latches rom_inst, if_pc=RESET_PC, if_valid=1, pc=RESET_PC+1, state goes to RUN. If stall is high, the FSM stays in BOOT.
  - RUN: normal operation. Per-edge priority, highest first: halt_req, redirect, stall, sequential.
  - HALT: pc, if_inst and if_pc frozen; if_valid=0; halted=1. Exits only on rst. All other inputs ignored.
- Redirects are honoured only when if_valid=1; with if_valid=0, branch_taken and jump are ignored.
- jump (wins over branch_taken if both high): next pc = jump_target[PC_WIDTH-1:0].
- branch_taken: next pc = (if_pc + 1 + branch_offset) mod 2^PC_WIDTH, using the low PC_WIDTH bits of the sign-extended offset.
- On any redirect:
  - The instruction currently at pc is wrong-path. Next edge: if_inst=0, if_valid=0, if_pc unchanged.
  - Redirect overrides stall.
  - Branch penalty is one bubble cycle.
- stall with no redirect: pc, if_inst, if_pc and if_valid all hold.
- Sequential fetch:
  - if_inst <= rom_inst, if_pc <= pc, if_valid <= 1.
  - pc <= pc+1, wrapping from 2^PC_WIDTH-1 to 0 with no flag.
- halt_req in RUN: next edge enters HALT and if_valid=0. An in-flight redirect in the same cycle is discarded.
- Latency: an instruction appears on if_inst one cycle after its address appears on pc.
- rst asserted mid-operation (including during a stall or in HALT) returns all state to reset values on that edge.
- Outputs are registered. The only combinational path is rom_inst -> IR input; there are no combinational input-to-output paths.

Test Plan:
- Reset, then 4 free-running cycles, no stall -> pc sequence 0,1,2,3,4; if_valid 0,1,1,1,1; at the 4th post-reset edge if_pc=3 and if_inst=rom[3].
- Run until if_pc=0x0A, then pulse branch_taken with branch_offset=0x0001 for one cycle -> next cycle pc=0x0C, if_valid=0; the following cycle if_pc=0x0C and if_inst=rom[0x0C].
- At if_pc=0x0C, assert jump with jump_target=0x0000008 -> pc=0x08 and one bubble, then if_pc=0x08; also assert branch_taken in the same cycle -> the jump target is used.
- Hold stall for 3 cycles at pc=5 -> pc, if_pc and if_inst unchanged; if_valid held. Then assert stall together with branch_taken (offset 0xFFFE, if_pc=4) -> pc=3 and a bubble, since redirect wins over stall.
- Let pc reach 0x1F -> next pc=0x00 and if_pc=0x1F. Separately, branch with if_pc=0x1E and offset 0x0003 -> pc=0x02.
- Assert halt_req at pc=7 -> halted=1, if_valid=0, pc stays 7 for 5 cycles despite jump pulses. Then assert rst -> pc=0, halted=0, state BOOT; first valid instruction one cycle after release.
